// File: rtl/alu_result_buffer.sv
// alu_result_buffer: first-word-fall-through result FIFO between the ALU
// result bus and a valid/ready reader. It reports occupancy and keeps a
// sticky flag that records any write dropped because the queue was full.
module alu_result_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [DATA_WIDTH-1:0]      in_data,
    input  logic                       load,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow,
    input  logic                       clear_overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  pop;
    logic                  wr_acc;
    logic                  drop;

    // A pop in the same cycle frees a slot, so a write to a full queue is
    // accepted when it coincides with a pop.
    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign pop      = out_valid && out_ready;
    assign wr_acc   = load && (!full || pop);
    assign drop     = load && full && !pop;

    // The head entry comes from registered state only. It is masked to 0
    // when the queue is empty, so stale storage never shows on the output.
    assign out_valid = !empty;
    assign out_data  = empty ? '0 : mem[rd_ptr];

    // Storage write. Entries are not reset because the output is masked
    // while the queue is empty. A load during reset is ignored.
    always_ff @(posedge clk) begin
        if (!reset && wr_acc)
            mem[wr_ptr] <= in_data;
    end

    // Pointers, occupancy and the sticky overflow flag. If a write is
    // dropped in the same cycle as a clear, the set takes priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_acc)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (wr_acc && !pop)
                count <= count + CW'(1);
            else if (pop && !wr_acc)
                count <= count - CW'(1);
            if (drop)
                overflow <= 1'b1;
            else if (clear_overflow)
                overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_result_buffer.sv
// Directed bench for alu_result_buffer. Expected values are written out by
// hand. Outputs are sampled 1 time unit after each rising edge.
module tb_alu_result_buffer;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_data;
    logic       load;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] count;
    logic       full;
    logic       empty;
    logic       overflow;
    logic       clear_overflow;

    int checks   = 0;
    int failures = 0;

    alu_result_buffer #(.DATA_WIDTH(8), .DEPTH(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .in_data        (in_data),
        .load           (load),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .count          (count),
        .full           (full),
        .empty          (empty),
        .overflow       (overflow),
        .clear_overflow (clear_overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        load = 1'b1; in_data = d;
        tick();
        load = 1'b0;
    endtask

    initial begin
        reset = 1'b1; load = 1'b0; in_data = 8'h00;
        out_ready = 1'b0; clear_overflow = 1'b0;
        #1;
        tick();
        reset = 1'b0;

        // 1. reset state; ready while empty does nothing
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 8'h00);
        chk("rst_ovf", overflow, 0);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        chk("empty_pop_count", count, 0);
        chk("empty_pop_valid", out_valid, 0);

        // 2. basic FIFO order
        push(8'hAA);
        chk("first_valid", out_valid, 1);
        chk("first_data", out_data, 8'hAA);
        push(8'hF0);
        chk("two_count", count, 2);
        chk("two_head", out_data, 8'hAA);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        chk("pop1_data", out_data, 8'hF0);
        chk("pop1_count", count, 1);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        chk("pop2_data", out_data, 8'h00);
        chk("pop2_empty", empty, 1);

        // 3. fill, overflow, drain, clear
        for (int i = 1; i <= 4; i++) push(8'(i));
        chk("fill_full", full, 1);
        chk("fill_count", count, 4);
        push(8'h05);
        chk("ovf_set", overflow, 1);
        chk("ovf_count", count, 4);
        for (int i = 1; i <= 4; i++) begin
            chk("ovf_drain", out_data, 32'(i));
            out_ready = 1'b1; tick(); out_ready = 1'b0;
        end
        chk("ovf_drain_empty", empty, 1);
        chk("ovf_sticky", overflow, 1);
        clear_overflow = 1'b1; tick(); clear_overflow = 1'b0;
        chk("ovf_clear", overflow, 0);

        // 4. write while full with simultaneous pop
        for (int i = 1; i <= 4; i++) push(8'(i));
        load = 1'b1; in_data = 8'h05; out_ready = 1'b1;
        tick();
        load = 1'b0; out_ready = 1'b0;
        chk("fullpop_ovf", overflow, 0);
        chk("fullpop_count", count, 4);
        for (int i = 2; i <= 5; i++) begin
            chk("fullpop_drain", out_data, 32'(i));
            out_ready = 1'b1; tick(); out_ready = 1'b0;
        end
        chk("fullpop_empty", empty, 1);

        // 5. streaming across pointer wrap
        load = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data = 8'h10 + 8'(i);
            tick();
            chk("stream_count", count, 1);
            chk("stream_data", out_data, 32'h10 + 32'(i));
        end
        load = 1'b0;
        tick();
        out_ready = 1'b0;
        chk("stream_end_empty", empty, 1);
        chk("stream_end_data", out_data, 0);

        // 6. reset mid-operation, then set-wins overflow
        push(8'hA1); push(8'hA2); push(8'hA3);
        chk("pre_rst_count", count, 3);
        reset = 1'b1; load = 1'b1; in_data = 8'h77;
        tick();
        reset = 1'b0; load = 1'b0;
        chk("midrst_count", count, 0);
        chk("midrst_data", out_data, 8'h00);
        chk("midrst_valid", out_valid, 0);
        push(8'h55);
        chk("postrst_head", out_data, 8'h55);
        push(8'h56); push(8'h57); push(8'h58);
        chk("refill_full", full, 1);
        load = 1'b1; in_data = 8'h99; clear_overflow = 1'b1;
        tick();
        load = 1'b0; clear_overflow = 1'b0;
        chk("setwins_ovf", overflow, 1);
        chk("setwins_count", count, 4);
        chk("setwins_head", out_data, 8'h55);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
